// File: rtl/display_scan_mux_if.sv
// Bus bundle for display_scan_mux: packed channel inputs, mode/scan controls and registered display outputs.
interface display_scan_mux_if #(
    parameter int DATA_W  = 12,
    parameter int NUM_CH  = 5,
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 16
);
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [1:0]               mode;
    logic [SEL_W-1:0]         manual_sel;
    logic [DWELL_W-1:0]       dwell;
    logic [NUM_CH-1:0]        ch_enable;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_valid;
    logic                     ch_change;

    modport master (
        output ch_data, mode, manual_sel, dwell, ch_enable,
        input  out_data, out_ch, out_valid, ch_change
    );

    modport slave (
        input  ch_data, mode, manual_sel, dwell, ch_enable,
        output out_data, out_ch, out_valid, ch_change
    );
endinterface

// File: rtl/display_scan_mux.sv
// Registered N-channel display multiplexer with manual select, auto-scan over enabled
// channels with programmable dwell, and freeze.
module display_scan_mux #(
    parameter int DATA_W  = 12,
    parameter int NUM_CH  = 5,
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 16
) (
    input logic               clk,
    input logic               rst,
    display_scan_mux_if.slave bus
);
    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;

    logic [DATA_W-1:0]  ch_arr [NUM_CH];

    logic [DATA_W-1:0]  out_data_reg,  out_data_next;
    logic [SEL_W-1:0]   out_ch_reg,    out_ch_next;
    logic               out_valid_reg, out_valid_next;
    logic               ch_change_reg, ch_change_next;
    logic [SEL_W-1:0]   scan_ch_reg,   scan_ch_next;
    logic [DWELL_W-1:0] dwell_cnt_reg, dwell_cnt_next;
    logic [1:0]         prev_mode_reg;

    logic [SEL_W-1:0]   next_en_ch;
    logic [SEL_W:0]     idx_wide;
    logic [SEL_W-1:0]   man_sel;
    logic [DWELL_W-1:0] dwell_last;
    logic [DWELL_W-1:0] cnt_eff;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_arr[gi] = bus.ch_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Nearest enabled channel after scan_ch, wrapping modulo NUM_CH; the loop runs from the
    // farthest offset down so the closest enabled channel wins.
    always_comb begin
        next_en_ch = scan_ch_reg;
        idx_wide   = '0;
        for (int off = NUM_CH - 1; off >= 1; off--) begin
            idx_wide = {1'b0, scan_ch_reg} + (SEL_W+1)'(off);
            if (idx_wide >= (SEL_W+1)'(NUM_CH))
                idx_wide = idx_wide - (SEL_W+1)'(NUM_CH);
            if (bus.ch_enable[idx_wide[SEL_W-1:0]])
                next_en_ch = idx_wide[SEL_W-1:0];
        end
    end

    assign man_sel    = ({1'b0, bus.manual_sel} < (SEL_W+1)'(NUM_CH)) ? bus.manual_sel : '0;
    assign dwell_last = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
    // Entering auto restarts the dwell on the stored channel in the entry cycle itself.
    assign cnt_eff    = (prev_mode_reg != MODE_AUTO) ? '0 : dwell_cnt_reg;

    always_comb begin
        out_data_next  = out_data_reg;
        out_ch_next    = out_ch_reg;
        out_valid_next = out_valid_reg;
        scan_ch_next   = scan_ch_reg;
        dwell_cnt_next = dwell_cnt_reg;
        case (bus.mode)
            MODE_MANUAL: begin
                out_data_next  = ch_arr[man_sel];
                out_ch_next    = man_sel;
                out_valid_next = 1'b1;
                dwell_cnt_next = '0;
            end
            MODE_AUTO: begin
                if (bus.ch_enable == '0) begin
                    out_valid_next = 1'b0;
                end else begin
                    out_data_next  = ch_arr[scan_ch_reg];
                    out_ch_next    = scan_ch_reg;
                    out_valid_next = 1'b1;
                    // A disabled current channel is shown once, then skipped immediately.
                    if (!bus.ch_enable[scan_ch_reg] || cnt_eff >= dwell_last) begin
                        scan_ch_next   = next_en_ch;
                        dwell_cnt_next = '0;
                    end else begin
                        dwell_cnt_next = cnt_eff + DWELL_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
        ch_change_next = (out_ch_next != out_ch_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
            ch_change_reg <= 1'b0;
            scan_ch_reg   <= '0;
            dwell_cnt_reg <= '0;
            prev_mode_reg <= MODE_MANUAL;
        end else begin
            out_data_reg  <= out_data_next;
            out_ch_reg    <= out_ch_next;
            out_valid_reg <= out_valid_next;
            ch_change_reg <= ch_change_next;
            scan_ch_reg   <= scan_ch_next;
            dwell_cnt_reg <= dwell_cnt_next;
            prev_mode_reg <= bus.mode;
        end
    end

    assign bus.out_data  = out_data_reg;
    assign bus.out_ch    = out_ch_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.ch_change = ch_change_reg;
endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux: expectations are queued when inputs are driven
// and compared one cycle later against the registered outputs.
module tb_display_scan_mux;
    localparam int DATA_W  = 12;
    localparam int NUM_CH  = 5;
    localparam int SEL_W   = 3;
    localparam int DWELL_W = 16;

    typedef struct {
        string             tag;
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  ch;
        logic              valid;
        logic              change;
        bit                chk_change;
    } exp_t;

    logic clk;
    logic rst;
    int   checks_cnt;
    int   fail_cnt;
    exp_t sb_q[$];

    display_scan_mux_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

    display_scan_mux #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] cv(input int k);
        return DATA_W'(12'h100 + k);
    endfunction

    task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
        bus.ch_data[k*DATA_W +: DATA_W] = v;
    endtask

    task automatic step(input string tag, input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] c,
                        input logic v, input logic chg, input bit chk_chg);
        exp_t e;
        e.tag = tag; e.data = d; e.ch = c; e.valid = v; e.change = chg; e.chk_change = chk_chg;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({e.tag, ".data"},  int'(bus.out_data),  int'(e.data));
        check({e.tag, ".ch"},    int'(bus.out_ch),    int'(e.ch));
        check({e.tag, ".valid"}, int'(bus.out_valid), int'(e.valid));
        if (e.chk_change)
            check({e.tag, ".change"}, int'(bus.ch_change), int'(e.change));
        $display("step %-12s out_data=0x%03h out_ch=%0d valid=%0b change=%0b",
                 e.tag, bus.out_data, bus.out_ch, bus.out_valid, bus.ch_change);
    endtask

    initial begin
        int d2_list[10];
        int prev_ch;
        checks_cnt = 0;
        fail_cnt   = 0;
        d2_list    = '{2, 4, 4, 1, 1, 4, 4, 1, 1, 4};

        rst            = 1'b1;
        bus.mode       = 2'b00;
        bus.manual_sel = 3'd2;
        bus.dwell      = 16'd3;
        bus.ch_enable  = 5'b11111;
        bus.ch_data    = '0;
        for (int k = 0; k < NUM_CH; k++) set_ch(k, cv(k));

        step("rst0", '0, '0, 1'b0, 1'b0, 1'b1);
        step("rst1", '0, '0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;

        // Manual select, latency and out-of-range fallback
        step("man_sel2", cv(2), 3'd2, 1'b1, 1'b0, 1'b0);
        step("man_hold", cv(2), 3'd2, 1'b1, 1'b0, 1'b1);
        set_ch(2, 12'hABC);
        step("man_lat", 12'hABC, 3'd2, 1'b1, 1'b0, 1'b1);
        set_ch(2, cv(2));
        bus.manual_sel = 3'd6;
        step("man_oor", cv(0), 3'd0, 1'b1, 1'b1, 1'b1);
        bus.manual_sel = 3'd4;
        step("man_sel4", cv(4), 3'd4, 1'b1, 1'b1, 1'b1);

        // Auto scan, dwell 3, all enabled, including the 4->0 wrap
        bus.mode = 2'b01;
        for (int i = 0; i < 16; i++) begin
            int c;
            c = (i / 3) % NUM_CH;
            step("auto_d3", cv(c), SEL_W'(c), 1'b1, (i % 3) == 0, 1'b1);
        end

        bus.mode = 2'b00;
        bus.manual_sel = 3'd0;
        step("man_sel0", cv(0), 3'd0, 1'b1, 1'b0, 1'b1);

        // Dwell 0 behaves as 1
        bus.mode  = 2'b01;
        bus.dwell = 16'd0;
        for (int i = 0; i < 7; i++) begin
            int c;
            c = i % NUM_CH;
            step("auto_d0", cv(c), SEL_W'(c), 1'b1, i != 0, 1'b1);
        end

        // Sparse mask; the pointer sits on disabled channel 2, shown for one cycle
        bus.dwell     = 16'd2;
        bus.ch_enable = 5'b10010;
        prev_ch = 1;
        for (int i = 0; i < 10; i++) begin
            step("auto_mask", cv(d2_list[i]), SEL_W'(d2_list[i]), 1'b1, d2_list[i] != prev_ch, 1'b1);
            prev_ch = d2_list[i];
        end

        bus.ch_enable = 5'b00010;
        step("dis4_a", cv(4), 3'd4, 1'b1, 1'b0, 1'b1);
        step("dis4_b", cv(1), 3'd1, 1'b1, 1'b1, 1'b1);

        bus.ch_enable = 5'b00000;
        step("mask0_a", cv(1), 3'd1, 1'b0, 1'b0, 1'b1);
        step("mask0_b", cv(1), 3'd1, 1'b0, 1'b0, 1'b1);

        bus.ch_enable = 5'b11111;
        bus.dwell     = 16'd3;
        step("resume_a", cv(1), 3'd1, 1'b1, 1'b0, 1'b1);
        step("resume_b", cv(1), 3'd1, 1'b1, 1'b0, 1'b1);
        step("to_ch2", cv(2), 3'd2, 1'b1, 1'b1, 1'b1);

        // Freeze mid-dwell; outputs must ignore channel data changes
        bus.mode = 2'b10;
        set_ch(2, 12'h555);
        for (int i = 0; i < 10; i++) step("freeze", cv(2), 3'd2, 1'b1, 1'b0, 1'b1);
        set_ch(2, cv(2));

        bus.mode = 2'b01;
        for (int i = 0; i < 3; i++) step("unfreeze", cv(2), 3'd2, 1'b1, 1'b0, 1'b1);
        step("unfrz_adv", cv(3), 3'd3, 1'b1, 1'b1, 1'b1);

        // Reset in the middle of a scan
        rst = 1'b1;
        step("rst_mid", '0, '0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("post_rst", cv(0), 3'd0, 1'b1, 1'b0, 1'b1);
        step("post_rst_adv", cv(1), 3'd1, 1'b1, 1'b1, 1'b1);

        // Reserved mode behaves as freeze
        bus.mode = 2'b11;
        step("rsvd_a", cv(1), 3'd1, 1'b1, 1'b0, 1'b1);
        step("rsvd_b", cv(1), 3'd1, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end
endmodule
